// File: rtl/mouse_master_sm.sv
// PS/2 mouse upstream controller: runs the 0xFF/0xF4 initialisation handshake,
// then assembles 3-byte movement packets and publishes them with an interrupt pulse.
module mouse_master_sm #(
  parameter int unsigned RESET_WAIT = 500000,
  parameter int unsigned TIMEOUT    = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic [7:0] BYTE_RECEIVED,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    WAIT_RESET   = 4'd0,
    SEND_FF      = 4'd1,
    WAIT_SENT_FF = 4'd2,
    ACK_FF       = 4'd3,
    SELFTEST     = 4'd4,
    DEVICE_ID    = 4'd5,
    SEND_F4      = 4'd6,
    WAIT_SENT_F4 = 4'd7,
    ACK_F4       = 4'd8,
    GET_STATUS   = 4'd9,
    GET_DX       = 4'd10,
    GET_DY       = 4'd11,
    PUBLISH      = 4'd12
  } state_t;

  state_t      state, nxt;
  logic [31:0] count;
  logic [7:0]  shadow_status, shadow_dx, shadow_dy;
  logic        timeout, rx_ok, reset_done;

  assign timeout    = (count == 32'(TIMEOUT - 1));
  assign reset_done = (count == 32'(RESET_WAIT - 1));
  assign rx_ok      = BYTE_READ && (BYTE_ERROR_CODE == 2'd0);

  // Received pulses take priority over the timeout in every guarded wait.
  always_comb begin
    nxt = state;
    case (state)
      WAIT_RESET:   if (reset_done) nxt = SEND_FF;
      SEND_FF:      nxt = WAIT_SENT_FF;
      WAIT_SENT_FF: if (BYTE_SENT) nxt = ACK_FF; else if (timeout) nxt = WAIT_RESET;
      ACK_FF:       if (BYTE_READ) nxt = (rx_ok && BYTE_RECEIVED == 8'hFA) ? SELFTEST : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      SELFTEST:     if (BYTE_READ) nxt = (rx_ok && BYTE_RECEIVED == 8'hAA) ? DEVICE_ID : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      DEVICE_ID:    if (BYTE_READ) nxt = (rx_ok && BYTE_RECEIVED == 8'h00) ? SEND_F4 : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      SEND_F4:      nxt = WAIT_SENT_F4;
      WAIT_SENT_F4: if (BYTE_SENT) nxt = ACK_F4; else if (timeout) nxt = WAIT_RESET;
      ACK_F4:       if (BYTE_READ) nxt = (rx_ok && BYTE_RECEIVED == 8'hFA) ? GET_STATUS : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      GET_STATUS:   if (BYTE_READ) nxt = rx_ok ? GET_DX : WAIT_RESET;
      GET_DX:       if (BYTE_READ) nxt = rx_ok ? GET_DY : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      GET_DY:       if (BYTE_READ) nxt = rx_ok ? PUBLISH : WAIT_RESET;
                    else if (timeout) nxt = WAIT_RESET;
      PUBLISH:      nxt = GET_STATUS;
      default:      nxt = WAIT_RESET;
    endcase
  end

  // Per-state outputs are decoded from the next state so they line up with MASTER_STATE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= WAIT_RESET;
      count          <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= '0;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      SEND_INTERRUPT <= 1'b0;
      MASTER_STATE   <= '0;
      shadow_status  <= '0;
      shadow_dx      <= '0;
      shadow_dy      <= '0;
    end else begin
      state        <= nxt;
      count        <= (nxt != state) ? '0 : count + 32'd1;
      MASTER_STATE <= nxt;
      SEND_BYTE    <= (nxt == SEND_FF) || (nxt == SEND_F4);
      if (nxt == SEND_FF) BYTE_TO_SEND <= 8'hFF;
      else if (nxt == SEND_F4) BYTE_TO_SEND <= 8'hF4;
      READ_ENABLE <= (nxt == ACK_FF) || (nxt == SELFTEST) || (nxt == DEVICE_ID) ||
                     (nxt == ACK_F4) || (nxt == GET_STATUS) || (nxt == GET_DX) ||
                     (nxt == GET_DY) || (nxt == PUBLISH);
      if (state == GET_STATUS && rx_ok) shadow_status <= BYTE_RECEIVED;
      if (state == GET_DX && rx_ok) shadow_dx <= BYTE_RECEIVED;
      if (state == GET_DY && rx_ok) shadow_dy <= BYTE_RECEIVED;
      SEND_INTERRUPT <= (state == PUBLISH);
      if (state == PUBLISH) begin
        MOUSE_STATUS <= shadow_status;
        MOUSE_DX     <= shadow_dx;
        MOUSE_DY     <= shadow_dy;
      end
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: init handshake, packets, errors, timeout, reset.
module tb_mouse_master_sm;

  localparam int unsigned RW = 8;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent = 1'b0;
  logic       read_enable;
  logic       byte_read = 1'b0;
  logic [1:0] byte_error_code = 2'd0;
  logic [7:0] byte_received = 8'h00;
  logic [7:0] mouse_status, mouse_dx, mouse_dy;
  logic       send_interrupt;
  logic [3:0] master_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mouse_master_sm #(.RESET_WAIT(RW), .TIMEOUT(TO)) dut (
    .CLK(clk), .RESET(reset),
    .SEND_BYTE(send_byte), .BYTE_TO_SEND(byte_to_send), .BYTE_SENT(byte_sent),
    .READ_ENABLE(read_enable), .BYTE_READ(byte_read),
    .BYTE_ERROR_CODE(byte_error_code), .BYTE_RECEIVED(byte_received),
    .MOUSE_STATUS(mouse_status), .MOUSE_DX(mouse_dx), .MOUSE_DY(mouse_dy),
    .SEND_INTERRUPT(send_interrupt), .MASTER_STATE(master_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_sent();
    byte_sent = 1'b1;
    @(negedge clk);
    byte_sent = 1'b0;
  endtask

  task automatic pulse_read(input logic [7:0] b, input logic [1:0] e);
    byte_read = 1'b1; byte_received = b; byte_error_code = e;
    @(negedge clk);
    byte_read = 1'b0; byte_error_code = 2'd0;
  endtask

  // Bounded wait for a transmit request; n = cycles waited.
  task automatic wait_send(output int n);
    n = 0;
    while (send_byte !== 1'b1 && n < int'(RW) + 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (master_state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", master_state); end
    checks++; if (send_byte !== 1'b0 || byte_to_send !== 8'h00 || read_enable !== 1'b0) begin
      failures++; $display("FAIL reset_tx: got send=%b byte=%h ren=%b expected 0 00 0", send_byte, byte_to_send, read_enable); end
    checks++; if (mouse_status !== 8'h00 || mouse_dx !== 8'h00 || mouse_dy !== 8'h00 || send_interrupt !== 1'b0) begin
      failures++; $display("FAIL reset_mouse: got %h %h %h irq=%b expected 00 00 00 0", mouse_status, mouse_dx, mouse_dy, send_interrupt); end
  endtask

  task automatic test_init();
    int n;
    wait_send(n);
    checks++; if (n != int'(RW)) begin failures++; $display("FAIL init_wait: got %0d expected %0d", n, RW); end
    checks++; if (byte_to_send !== 8'hFF || master_state !== 4'd1) begin
      failures++; $display("FAIL init_ff: got byte=%h state=%0d expected ff 1", byte_to_send, master_state); end
    tick();
    checks++; if (send_byte !== 1'b0 || master_state !== 4'd2 || byte_to_send !== 8'hFF) begin
      failures++; $display("FAIL init_wait_sent: got send=%b state=%0d byte=%h expected 0 2 ff", send_byte, master_state, byte_to_send); end
    pulse_read(8'hFA, 2'd0);
    checks++; if (master_state !== 4'd2) begin failures++; $display("FAIL drop_read_s2: got %0d expected 2", master_state); end
    pulse_sent();
    checks++; if (master_state !== 4'd3 || read_enable !== 1'b1) begin
      failures++; $display("FAIL init_ack_ff: got state=%0d ren=%b expected 3 1", master_state, read_enable); end
    pulse_read(8'hFA, 2'd0);
    pulse_read(8'hAA, 2'd0);
    checks++; if (master_state !== 4'd5) begin failures++; $display("FAIL init_devid: got %0d expected 5", master_state); end
    pulse_read(8'h00, 2'd0);
    checks++; if (send_byte !== 1'b1 || byte_to_send !== 8'hF4 || master_state !== 4'd6 || read_enable !== 1'b0) begin
      failures++; $display("FAIL init_f4: got send=%b byte=%h state=%0d ren=%b expected 1 f4 6 0", send_byte, byte_to_send, master_state, read_enable); end
    tick();
    pulse_sent();
    pulse_read(8'hFA, 2'd0);
    checks++; if (master_state !== 4'd9 || read_enable !== 1'b1) begin
      failures++; $display("FAIL init_stream: got state=%0d ren=%b expected 9 1", master_state, read_enable); end
  endtask

  task automatic test_packet();
    pulse_read(8'h09, 2'd0); tick();
    pulse_read(8'h05, 2'd0); tick();
    pulse_read(8'hFB, 2'd0);
    checks++; if (master_state !== 4'd12 || send_interrupt !== 1'b0 || mouse_status !== 8'h00) begin
      failures++; $display("FAIL pkt_lat1: got state=%0d irq=%b status=%h expected 12 0 00", master_state, send_interrupt, mouse_status); end
    tick();
    checks++; if (mouse_status !== 8'h09 || mouse_dx !== 8'h05 || mouse_dy !== 8'hFB || send_interrupt !== 1'b1) begin
      failures++; $display("FAIL pkt_pub: got %h %h %h irq=%b expected 09 05 fb 1", mouse_status, mouse_dx, mouse_dy, send_interrupt); end
    checks++; if (master_state !== 4'd9) begin failures++; $display("FAIL pkt_back9: got %0d expected 9", master_state); end
    tick();
    checks++; if (send_interrupt !== 1'b0) begin failures++; $display("FAIL pkt_irq_width: got %b expected 0", send_interrupt); end
  endtask

  task automatic test_err_packet();
    int irqs;
    pulse_read(8'h08, 2'd0); tick();
    pulse_read(8'h01, 2'd0); tick();
    pulse_read(8'h02, 2'd0); tick();
    checks++; if (mouse_status !== 8'h08 || mouse_dx !== 8'h01 || mouse_dy !== 8'h02 || send_interrupt !== 1'b1) begin
      failures++; $display("FAIL err_good_pub: got %h %h %h irq=%b expected 08 01 02 1", mouse_status, mouse_dx, mouse_dy, send_interrupt); end
    // Back-to-back: next packet starts the cycle right after the publish.
    pulse_read(8'h08, 2'd0);
    checks++; if (master_state !== 4'd10) begin failures++; $display("FAIL err_dx_state: got %0d expected 10", master_state); end
    pulse_read(8'h77, 2'd1);
    irqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (send_interrupt === 1'b1) irqs++;
      tick();
    end
    checks++; if (irqs != 0) begin failures++; $display("FAIL err_no_irq: got %0d pulses expected 0", irqs); end
    checks++; if (master_state !== 4'd0 || read_enable !== 1'b0) begin
      failures++; $display("FAIL err_state0: got state=%0d ren=%b expected 0 0", master_state, read_enable); end
    checks++; if (mouse_status !== 8'h08 || mouse_dx !== 8'h01 || mouse_dy !== 8'h02) begin
      failures++; $display("FAIL err_hold: got %h %h %h expected 08 01 02", mouse_status, mouse_dx, mouse_dy); end
  endtask

  task automatic test_bad_ack();
    int n;
    wait_send(n);
    checks++; if (n != int'(RW) - 4) begin failures++; $display("FAIL reinit_wait: got %0d expected %0d", n, RW - 4); end
    tick();
    pulse_sent();
    pulse_read(8'hFE, 2'd0);
    checks++; if (master_state !== 4'd0 || read_enable !== 1'b0) begin
      failures++; $display("FAIL badack_state: got state=%0d ren=%b expected 0 0", master_state, read_enable); end
    wait_send(n);
    checks++; if (n != int'(RW) || byte_to_send !== 8'hFF) begin
      failures++; $display("FAIL badack_resend: got wait=%0d byte=%h expected %0d ff", n, byte_to_send, RW); end
  endtask

  task automatic test_timeout();
    int n, bad;
    tick();
    n = 0; bad = 0;
    while (master_state === 4'd2 && n < int'(TO) + 5) begin
      if (send_byte !== 1'b0) bad++;
      tick();
      n++;
    end
    checks++; if (n != int'(TO) || master_state !== 4'd0) begin
      failures++; $display("FAIL timeout_len: got cycles=%0d state=%0d expected %0d 0", n, master_state, TO); end
    checks++; if (bad != 0) begin failures++; $display("FAIL timeout_send_low: got %0d high cycles expected 0", bad); end
    wait_send(n);
    tick();
    repeat (TO - 1) tick();
    pulse_sent();
    checks++; if (master_state !== 4'd3) begin failures++; $display("FAIL sent_beats_timeout: got %0d expected 3", master_state); end
  endtask

  task automatic test_reset_mid();
    pulse_read(8'hFA, 2'd0);
    pulse_read(8'hAA, 2'd0);
    pulse_read(8'h00, 2'd0);
    tick();
    pulse_sent();
    pulse_read(8'hFA, 2'd0);
    pulse_read(8'h11, 2'd0);
    checks++; if (master_state !== 4'd10) begin failures++; $display("FAIL mid_pre: got %0d expected 10", master_state); end
    reset = 1'b1;
    byte_read = 1'b1; byte_received = 8'h22;
    tick();
    reset = 1'b0; byte_read = 1'b0;
    checks++; if (master_state !== 4'd0 || read_enable !== 1'b0 || send_byte !== 1'b0 || byte_to_send !== 8'h00) begin
      failures++; $display("FAIL mid_ctrl: got state=%0d ren=%b send=%b byte=%h expected 0 0 0 00", master_state, read_enable, send_byte, byte_to_send); end
    checks++; if (mouse_status !== 8'h00 || mouse_dx !== 8'h00 || mouse_dy !== 8'h00 || send_interrupt !== 1'b0) begin
      failures++; $display("FAIL mid_mouse: got %h %h %h irq=%b expected 00 00 00 0", mouse_status, mouse_dx, mouse_dy, send_interrupt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_packet();
    test_err_packet();
    test_bad_ack();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
